// File: rtl/lvds_tx_frame_sequencer_if.sv
// Word-source handshake between the link layer and the LVDS frame sequencer.
// The source also carries the training request alongside its data.
interface lvds_tx_frame_sequencer_if;
    logic [9:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       train_req;

    modport master (
        output in_data,
        output in_valid,
        output train_req,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  train_req,
        output in_ready
    );
endinterface

// File: rtl/lvds_tx_frame_sequencer.sv
// Frame sequencer for an LVDS serializer channel: divides the fast clock into frames,
// pulses the load strobe once per frame and presents training, user or idle words.
module lvds_tx_frame_sequencer #(
    parameter int unsigned DESER_FACTOR  = 4,
    parameter int unsigned TRAIN_WORDS   = 16,
    parameter logic [9:0]  TRAIN_PATTERN = 10'h00C,
    parameter logic [9:0]  IDLE_PATTERN  = 10'h005
) (
    input  logic                            tx_fastclk,
    input  logic                            tx_reset_n,
    lvds_tx_frame_sequencer_if.slave        src,
    output logic [9:0]                      tx_in,
    output logic                            tx_enable,
    output logic                            train_busy,
    output logic [15:0]                     underrun_cnt
);

    localparam int unsigned     PhaseW    = $clog2(DESER_FACTOR);
    localparam logic [PhaseW-1:0] LastPhase = PhaseW'(DESER_FACTOR - 1);
    localparam logic [7:0]      LastTrain = 8'(TRAIN_WORDS - 1);
    // Only the low DESER_FACTOR bits of the training word reach the line.
    localparam logic [9:0]      TrainWord =
        TRAIN_PATTERN & 10'((11'd1 << DESER_FACTOR) - 11'd1);

    typedef enum logic {StTrain, StData} state_e;

    state_e              state;
    logic [PhaseW-1:0]   phase;
    logic [PhaseW-1:0]   phase_next;
    logic [7:0]          train_cnt;
    logic                pending;
    logic                boundary;
    logic                retrain;

    assign boundary     = (phase == LastPhase);
    assign phase_next   = boundary ? '0 : phase + PhaseW'(1);
    assign retrain      = pending || src.train_req;
    assign src.in_ready = (state == StData) && boundary && !retrain;

    always_ff @(posedge tx_fastclk or negedge tx_reset_n) begin
        if (!tx_reset_n) begin
            state        <= StTrain;
            phase        <= '0;
            train_cnt    <= '0;
            pending      <= 1'b0;
            tx_in        <= '0;
            tx_enable    <= 1'b0;
            train_busy   <= 1'b1;
            underrun_cnt <= '0;
        end else begin
            phase     <= phase_next;
            // Registered strobe lines up with the last-phase cycle of each frame.
            tx_enable <= (phase_next == LastPhase);
            if (boundary) begin
                pending <= 1'b0;
                unique case (state)
                    StTrain: begin
                        tx_in <= TrainWord;
                        if (train_cnt == LastTrain) begin
                            train_cnt  <= '0;
                            state      <= StData;
                            train_busy <= 1'b0;
                        end else begin
                            train_cnt <= train_cnt + 8'd1;
                        end
                    end
                    StData: begin
                        if (retrain) begin
                            // Request beats a waiting word; the source keeps holding it.
                            tx_in      <= TrainWord;
                            state      <= StTrain;
                            train_busy <= 1'b1;
                        end else if (src.in_valid) begin
                            tx_in <= src.in_data;
                        end else begin
                            tx_in <= IDLE_PATTERN;
                            if (underrun_cnt != 16'hFFFF) begin
                                underrun_cnt <= underrun_cnt + 16'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end else if (state == StData && src.train_req) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lvds_tx_frame_sequencer.sv
// Bench for lvds_tx_frame_sequencer: randomized source and training requests checked
// every cycle against a frame-level reference model, plus directed boundary checks.
module tb_lvds_tx_frame_sequencer;

    localparam int unsigned D  = 4;
    localparam int unsigned TW = 16;
    localparam logic [9:0]  TP = 10'h00C;
    localparam logic [9:0]  IP = 10'h005;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rst10_n;
    logic [9:0]  tx_in;
    logic        tx_enable;
    logic        train_busy;
    logic [15:0] underrun_cnt;
    logic [9:0]  tx_in10;
    logic        tx_enable10;
    logic        train_busy10;
    logic [15:0] underrun10;

    lvds_tx_frame_sequencer_if src ();
    lvds_tx_frame_sequencer_if src10 ();

    lvds_tx_frame_sequencer #(
        .DESER_FACTOR (D),
        .TRAIN_WORDS  (TW),
        .TRAIN_PATTERN(TP),
        .IDLE_PATTERN (IP)
    ) dut (
        .tx_fastclk  (clk),
        .tx_reset_n  (rst_n),
        .src         (src),
        .tx_in       (tx_in),
        .tx_enable   (tx_enable),
        .train_busy  (train_busy),
        .underrun_cnt(underrun_cnt)
    );

    lvds_tx_frame_sequencer #(
        .DESER_FACTOR (10),
        .TRAIN_WORDS  (2),
        .TRAIN_PATTERN(TP),
        .IDLE_PATTERN (IP)
    ) dut10 (
        .tx_fastclk  (clk),
        .tx_reset_n  (rst10_n),
        .src         (src10),
        .tx_in       (tx_in10),
        .tx_enable   (tx_enable10),
        .train_busy  (train_busy10),
        .underrun_cnt(underrun10)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: frames, training words left, pending request, word on the line.
    int         m_cyc;
    bit         m_train;
    int         m_left;
    bit         m_pend;
    logic [9:0] m_tx;
    int         m_under;
    bit         m_accept;
    logic [9:0] words[$];

    task automatic model_reset();
        m_cyc   = 0;
        m_train = 1'b1;
        m_left  = TW;
        m_pend  = 1'b0;
        m_tx    = '0;
        m_under = 0;
    endtask

    task automatic model_edge();
        bit last;
        last     = (m_cyc % D) == D - 1;
        m_accept = 1'b0;
        if (last) begin
            if (m_train) begin
                m_tx = TP;
                m_left--;
                if (m_left == 0) m_train = 1'b0;
            end else if (m_pend || src.train_req) begin
                m_tx    = TP;
                m_train = 1'b1;
                m_left  = TW;
                m_pend  = 1'b0;
            end else if (src.in_valid) begin
                m_tx     = src.in_data;
                m_accept = 1'b1;
            end else begin
                m_tx = IP;
                if (m_under < 65535) m_under++;
            end
        end else if (!m_train && src.train_req) begin
            m_pend = 1'b1;
        end
        m_cyc++;
    endtask

    // Called at posedge+1; drives one cycle of stimulus and checks it at the negedge.
    task automatic cycle(input bit req, input bit vld);
        bit last;
        src.train_req = req;
        src.in_valid  = vld;
        src.in_data   = words[0];
        @(negedge clk);
        last = (m_cyc % D) == D - 1;
        check_eq("tx_enable", tx_enable, last);
        check_eq("tx_in", tx_in, m_tx);
        check_eq("train_busy", train_busy, m_train);
        check_eq("underrun_cnt", underrun_cnt, m_under);
        check_eq("in_ready", src.in_ready, !m_train && last && !m_pend && !req);
        model_edge();
        if (m_accept) begin
            void'(words.pop_front());
            words.push_back(10'($urandom));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int req_pct, input int vld_pct);
        for (int i = 0; i < n; i++) begin
            cycle($urandom_range(99) < req_pct, $urandom_range(99) < vld_pct);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_tx_in"}, tx_in, 10'h000);
        check_eq({tag, "_tx_enable"}, tx_enable, 1'b0);
        check_eq({tag, "_in_ready"}, src.in_ready, 1'b0);
        check_eq({tag, "_train_busy"}, train_busy, 1'b1);
        check_eq({tag, "_underrun"}, underrun_cnt, 16'h0000);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] u0;
        logic [9:0]  w;
        int          expv;

        rst_n = 1'b0;
        rst10_n = 1'b0;
        src.train_req = 1'b0;  src.in_valid = 1'b0;  src.in_data = '0;
        src10.train_req = 1'b0; src10.in_valid = 1'b0; src10.in_data = '0;
        for (int i = 0; i < 8; i++) words.push_back(10'($urandom));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");

        // Bring-up: cycle 0 starts now.
        rst_n = 1'b1;
        run(63, 0, 0);
        check_eq("bringup_busy63", train_busy, 1'b1);
        check_eq("bringup_en63", tx_enable, 1'b1);
        check_eq("bringup_tx63", tx_in, TP);
        run(1, 0, 0);
        check_eq("bringup_busy64", train_busy, 1'b0);
        check_eq("bringup_tx64", tx_in, TP);
        run(4, 0, 0);
        check_eq("bringup_tx68", tx_in, IP);

        // Streaming.
        while (m_cyc % D != 0) cycle(1'b0, 1'b0);
        words.delete();
        words.push_back(10'h001);
        words.push_back(10'h002);
        words.push_back(10'h003);
        for (int i = 0; i < 5; i++) words.push_back(10'($urandom));
        u0 = underrun_cnt;
        run(D, 0, 100);
        check_eq("stream_w1", tx_in, 10'h001);
        run(D, 0, 100);
        check_eq("stream_w2", tx_in, 10'h002);
        run(D, 0, 100);
        check_eq("stream_w3", tx_in, 10'h003);
        check_eq("stream_no_underrun", underrun_cnt - u0, 16'd0);

        // Underrun for three frames.
        u0 = underrun_cnt;
        run(3 * D, 0, 0);
        check_eq("underrun_delta", underrun_cnt - u0, 16'd3);
        check_eq("underrun_tx", tx_in, IP);

        // Retrain request colliding with a valid word on the same boundary.
        while (m_cyc % D != D - 1) cycle(1'b0, 1'b0);
        w = words[0];
        cycle(1'b1, 1'b1);
        check_eq("collide_tx", tx_in, TP);
        check_eq("collide_busy", train_busy, 1'b1);
        run(16 * D, 0, 100);
        check_eq("collide_train_done", train_busy, 1'b0);
        check_eq("collide_last_train", tx_in, TP);
        run(D, 0, 100);
        check_eq("collide_held_word", tx_in, w);

        // Randomized traffic with occasional training requests.
        run(600, 3, 70);

        // Mid-burst reset at training frame 5, phase 2.
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(22, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(16 * D - 1, 0, 60);
        check_eq("midreset_busy63", train_busy, 1'b1);
        run(1, 0, 60);
        check_eq("midreset_busy64", train_busy, 1'b0);
        run(60, 3, 70);

        // DESER_FACTOR=10 instance: strobe period and counter saturation.
        rst10_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            check_eq("d10_enable", tx_enable10, (k % 10) == 9);
            @(posedge clk);
            #1;
        end
        check_eq("d10_underrun2", underrun10, 16'd2);
        check_eq("d10_idle", tx_in10, IP);
        force dut10.underrun_cnt = 16'hFFFC;
        #1;
        release dut10.underrun_cnt;
        for (int f = 1; f <= 5; f++) begin
            repeat (10) begin
                @(posedge clk);
                #1;
            end
            expv = 32'hFFFC + f;
            if (expv > 32'hFFFF) expv = 32'hFFFF;
            check_eq("d10_saturate", underrun10, expv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
